acc_core: RTL and testbench
===========================

ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 Parameter DW, default 8: accumulator, register file, data memory and I/O data width; legal 4..16.
REQ-002 Parameter AW, default 6: PC and memory address width; legal 2..8.
REQ-003 Parameter RW, default 3: register-select width, giving 2^RW registers; legal 1..3.
REQ-004 Port Clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1: asynchronous, active-low reset.
REQ-006 Port Start, input, 1: in IDLE or HALTED, sets PC=0 and begins execution.
REQ-007 Port Prog_we, input, 1: instruction-memory write enable.
REQ-008 Port Prog_addr, input, AW: instruction-memory write address.
REQ-009 Port Prog_data, input, 16: instruction word to write.
REQ-010 Port Input, input, DW: data for the IN instruction.
REQ-011 Port In_valid, input, 1: Input holds valid data.
REQ-012 Port In_ready, output, 1: high only in WAIT_IN.
REQ-013 Port Output, output, DW: registered output data.
REQ-014 Port Out_valid, output, 1: Output is being offered.
REQ-015 Port Out_ready, input, 1: consumer accepts Output.
REQ-016 Port Busy, output, 1: high in FETCH, EXEC, WAIT_IN and WAIT_OUT.
REQ-017 Port Halted, output, 1: high in HALTED.
REQ-018 Port Aeq0, output, 1: combinational, A==0.
REQ-019 Port Apos, output, 1: combinational, A!=0 and A[DW-1]==0.

Function
REQ-020 The block SHALL hold an instruction memory of 2^AW x 16 bits, a data memory of 2^AW x DW bits, a register file of 2^RW x DW bits, PC (AW bits), IR (16 bits) and A (DW bits).
REQ-021 Instruction fields SHALL be: opcode IR[15:12]; r = IR[8+RW-1:8]; addr = IR[AW-1:0]; imm = IR[7:0], sign-extended or truncated to DW.
REQ-022 The FSM SHALL have states IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT and HALTED.
REQ-023 IDLE or HALTED with Start=1 -> FETCH next cycle, with PC=0.
REQ-024 FETCH SHALL load IR from instruction memory at PC, set PC=PC+1 modulo 2^AW, and go to EXEC.
REQ-025 Each non-I/O instruction SHALL therefore take exactly 2 cycles.
REQ-026 EXEC SHALL perform the opcode, then go to FETCH unless another state is stated below.
REQ-027 Opcode 0 NOP: no state change.
REQ-028 Opcode 1 LDA: A=DMEM[addr]. Opcode 2 STA: DMEM[addr]=A.
REQ-029 Opcode 3 LDR: A=R[r]. Opcode 4 STR: R[r]=A.
REQ-030 Opcode 5 ADD: A=A+R[r]. Opcode 6 SUB: A=A-R[r]. Both wrap modulo 2^DW; no carry is kept.
REQ-031 Opcode 7 LDI: A=imm.
REQ-032 Opcode 8 IN: go to WAIT_IN.
REQ-033 Opcode 9 OUT: Output=A, Out_valid=1, go to WAIT_OUT.
REQ-034 Opcode A JZ: PC=addr if Aeq0. Opcode B JP: PC=addr if Apos. Opcode C JMP: PC=addr.
REQ-035 Opcode D JR: PC=PC+imm[AW-1:0], wrapping; PC has already been incremented.
REQ-036 Opcode E INC: A=A+1, wrapping.
REQ-037 Opcode F HALT: go to HALTED.
REQ-038 WAIT_IN: In_ready=1; on In_valid=1, A=Input and go to FETCH; otherwise stay, with no timeout.
REQ-039 WAIT_OUT: Out_valid=1 with Output stable; on Out_ready=1, Out_valid=0 the next cycle and go to FETCH.
REQ-040 Output SHALL hold its last value after the handshake.
REQ-041 Prog_we SHALL write only in IDLE or HALTED; it SHALL be ignored otherwise.
REQ-042 If Prog_we and Start are high in the same cycle, both SHALL take effect.
REQ-043 Start SHALL be ignored while Busy=1.
REQ-044 Data memory SHALL read asynchronously and write synchronously.
REQ-045 An STA followed by an LDA of the same address SHALL return the stored value.

Reset
REQ-046 Reset=0 SHALL immediately set state IDLE, PC=0, IR=0, A=0, Output=0, Out_valid=0, In_ready=0, Busy=0, Halted=0, and all registers to 0.
REQ-047 Reset SHALL not clear data or instruction memory.
REQ-048 Reset asserted mid-instruction, including in WAIT_IN or WAIT_OUT, SHALL abort the instruction with no memory write.

Verification
REQ-049 Program LDI 5; STR 1; LDI 3; ADD 1; OUT; HALT with Out_ready=1 -> Output=8, Out_valid pulses for 1 cycle, then Halted=1 after 13 cycles from Start.
REQ-050 DW=8: LDI 0x7F; INC; OUT -> Output=0x80, Apos=0, Aeq0=0. Then SUB of an equal register -> Aeq0=1.
REQ-051 IN with In_valid held low for 10 cycles, then In_valid=1 with Input=0x2A -> In_ready high all 11 cycles; A=0x2A after; Busy=1 throughout.
REQ-052 OUT with Out_ready low for 5 cycles -> Out_valid held and Output stable; it drops the cycle after Out_ready=1.
REQ-053 AW=6 with JMP 63 and a NOP at address 63 -> PC wraps to 0; JR imm=-2 loops back two instructions.
REQ-054 Reset pulsed low in WAIT_OUT -> outputs return to reset values asynchronously; Prog_we writes are accepted again; Start reruns from PC=0.

Source files
------------

// File: rtl/acc_core.sv
// Accumulator microcontroller core: 16-bit instruction memory, DW-bit data
// memory and register file, six-state fetch/execute sequencer with
// ready/valid input and output handshakes.
module acc_core #(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int RW = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Prog_we,
  input  logic [AW-1:0] Prog_addr,
  input  logic [15:0]   Prog_data,
  input  logic [DW-1:0] Input,
  input  logic          In_valid,
  output logic          In_ready,
  output logic [DW-1:0] Output,
  output logic          Out_valid,
  input  logic          Out_ready,
  output logic          Busy,
  output logic          Halted,
  output logic          Aeq0,
  output logic          Apos
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    WAIT_IN  = 3'd3,
    WAIT_OUT = 3'd4,
    HALTED   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_STA  = 4'h2,
    OP_LDR  = 4'h3,
    OP_STR  = 4'h4,
    OP_ADD  = 4'h5,
    OP_SUB  = 4'h6,
    OP_LDI  = 4'h7,
    OP_IN   = 4'h8,
    OP_OUT  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JP   = 4'hB,
    OP_JMP  = 4'hC,
    OP_JR   = 4'hD,
    OP_INC  = 4'hE,
    OP_HALT = 4'hF
  } op_t;

  localparam int NWORDS = 2**AW;
  localparam int NREGS  = 2**RW;

  // Architectural state
  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_out;
  logic [DW-1:0] r_rf   [NREGS];
  logic [15:0]   r_imem [NWORDS];
  logic [DW-1:0] r_dmem [NWORDS];

  // Decoded instruction fields
  op_t             w_op;
  logic [RW-1:0]   w_r;
  logic [AW-1:0]   w_addr;
  logic signed [7:0] w_imm8;
  logic [DW-1:0]   w_imm;
  logic [DW-1:0]   w_rval;
  logic [DW-1:0]   w_dval;
  logic            w_aeq0;
  logic            w_apos;
  logic            w_unused;

  // Next-state / control strobes
  state_t        w_state_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic [DW-1:0] w_a_nxt;
  logic          w_ir_ld;
  logic          w_out_ld;
  logic          w_rf_we;
  logic          w_dmem_we;
  logic          w_imem_we;

  assign w_op   = op_t'(r_ir[15:12]);
  assign w_r    = r_ir[8+RW-1:8];
  assign w_addr = r_ir[AW-1:0];
  assign w_imm8 = r_ir[7:0];
  // Signed cast: sign-extends when DW > 8, truncates when DW < 8.
  assign w_imm  = DW'(w_imm8);
  assign w_rval = r_rf[w_r];
  assign w_dval = r_dmem[w_addr];
  // IR bits above the register-select field are never decoded.
  assign w_unused = &{1'b0, r_ir[11:8+RW]};

  assign w_aeq0 = (r_a == '0);
  assign w_apos = !w_aeq0 && !r_a[DW-1];

  assign Aeq0      = w_aeq0;
  assign Apos      = w_apos;
  assign Output    = r_out;
  assign In_ready  = (r_state == WAIT_IN);
  assign Out_valid = (r_state == WAIT_OUT);
  assign Halted    = (r_state == HALTED);
  assign Busy      = (r_state == FETCH) || (r_state == EXEC) ||
                     (r_state == WAIT_IN) || (r_state == WAIT_OUT);

  // Sequencer: next state and datapath control for the current state
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_a_nxt     = r_a;
    w_ir_ld     = 1'b0;
    w_out_ld    = 1'b0;
    w_rf_we     = 1'b0;
    w_dmem_we   = 1'b0;
    w_imem_we   = 1'b0;
    case (r_state)
      IDLE, HALTED: begin
        w_imem_we = Prog_we;
        if (Start) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = '0;
        end
      end
      FETCH: begin
        w_ir_ld     = 1'b1;
        w_pc_nxt    = r_pc + AW'(1);
        w_state_nxt = EXEC;
      end
      EXEC: begin
        w_state_nxt = FETCH;
        case (w_op)
          OP_NOP:  ;
          OP_LDA:  w_a_nxt = w_dval;
          OP_STA:  w_dmem_we = 1'b1;
          OP_LDR:  w_a_nxt = w_rval;
          OP_STR:  w_rf_we = 1'b1;
          OP_ADD:  w_a_nxt = r_a + w_rval;
          OP_SUB:  w_a_nxt = r_a - w_rval;
          OP_LDI:  w_a_nxt = w_imm;
          OP_IN:   w_state_nxt = WAIT_IN;
          OP_OUT: begin
            w_out_ld    = 1'b1;
            w_state_nxt = WAIT_OUT;
          end
          OP_JZ:   if (w_aeq0) w_pc_nxt = w_addr;
          OP_JP:   if (w_apos) w_pc_nxt = w_addr;
          OP_JMP:  w_pc_nxt = w_addr;
          OP_JR:   w_pc_nxt = r_pc + r_ir[AW-1:0];
          OP_INC:  w_a_nxt = r_a + DW'(1);
          OP_HALT: w_state_nxt = HALTED;
          default: ;
        endcase
      end
      WAIT_IN: begin
        if (In_valid) begin
          w_a_nxt     = Input;
          w_state_nxt = FETCH;
        end
      end
      WAIT_OUT: begin
        if (Out_ready) w_state_nxt = FETCH;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // PC, IR, accumulator and output register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_a   <= '0;
      r_out <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      r_a  <= w_a_nxt;
      if (w_ir_ld)  r_ir  <= r_imem[r_pc];
      if (w_out_ld) r_out <= r_a;
    end
  end

  // Register file, cleared by reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_rf_we) begin
      r_rf[w_r] <= r_a;
    end
  end

  // Instruction and data memories: synchronous write, contents survive reset
  always_ff @(posedge Clock) begin
    if (w_imem_we) r_imem[Prog_addr] <= Prog_data;
    if (w_dmem_we) r_dmem[w_addr]    <= r_a;
  end

endmodule

// File: tb/tb_acc_core.sv
// Scoreboarded bench for acc_core: expected OUT values are queued before each
// run and compared on every Out_valid/Out_ready handshake.
module tb_acc_core;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int RW = 3;

  localparam logic [3:0] NOP = 4'h0, LDA = 4'h1, STA = 4'h2, LDR = 4'h3,
                         STR = 4'h4, ADD = 4'h5, SUB = 4'h6, LDI = 4'h7,
                         IN  = 4'h8, OUT = 4'h9, JZ  = 4'hA, JP  = 4'hB,
                         JMP = 4'hC, JR  = 4'hD, INC = 4'hE, HLT = 4'hF;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic          Prog_we;
  logic [AW-1:0] Prog_addr;
  logic [15:0]   Prog_data;
  logic [DW-1:0] Input;
  logic          In_valid;
  logic          In_ready;
  logic [DW-1:0] Output;
  logic          Out_valid;
  logic          Out_ready;
  logic          Busy;
  logic          Halted;
  logic          Aeq0;
  logic          Apos;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   ov_cnt = 0;
  logic [DW-1:0] sb [$];

  acc_core #(.DW(DW), .AW(AW), .RW(RW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Prog_we(Prog_we),
    .Prog_addr(Prog_addr), .Prog_data(Prog_data), .Input(Input),
    .In_valid(In_valid), .In_ready(In_ready), .Output(Output),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Busy(Busy),
    .Halted(Halted), .Aeq0(Aeq0), .Apos(Apos)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts offered cycles and scores each completed handshake
  always @(negedge Clock) begin
    logic [DW-1:0] e;
    if (Reset === 1'b1 && Out_valid === 1'b1) begin
      ov_cnt++;
      if (Out_ready === 1'b1) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", 32'(Output), 32'(e));
        end
      end
    end
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] r, input logic [7:0] v);
    return {op, r, v};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pw(input int unsigned a, input logic [15:0] d);
    Prog_we   = 1'b1;
    Prog_addr = AW'(a);
    Prog_data = d;
    tick();
    Prog_we   = 1'b0;
  endtask

  task automatic go();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int unsigned n = 0;
    while (Halted !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(Halted), 32'd1);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    int unsigned cnt;
    Reset = 1'b0; Start = 1'b0; Prog_we = 1'b0; Prog_addr = '0;
    Prog_data = '0; Input = '0; In_valid = 1'b0; Out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_busy",      32'(Busy),      32'd0);
    chk("rst_halted",    32'(Halted),    32'd0);
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_in_ready",  32'(In_ready),  32'd0);
    chk("rst_output",    32'(Output),    32'd0);
    chk("rst_aeq0",      32'(Aeq0),      32'd1);
    chk("rst_apos",      32'(Apos),      32'd0);
    Reset = 1'b1;
    tick();

    // 5 + 3 = 8, halt exactly 13 cycles after Start
    pw(0, ins(LDI, 0, 8'd5)); pw(1, ins(STR, 1, 0)); pw(2, ins(LDI, 0, 8'd3));
    pw(3, ins(ADD, 1, 0));    pw(4, ins(OUT, 0, 0)); pw(5, ins(HLT, 0, 0));
    sb.push_back(8'd8);
    ov_cnt = 0;
    go();
    chk("t1_busy_fetch", 32'(Busy), 32'd1);
    repeat (12) tick();
    chk("t1_not_halted_12", 32'(Halted), 32'd0);
    tick();
    chk("t1_halted_13", 32'(Halted), 32'd1);
    chk("t1_ov_pulse", ov_cnt, 32'd1);
    chk("t1_apos", 32'(Apos), 32'd1);
    chk("t1_aeq0", 32'(Aeq0), 32'd0);

    // 0x7F + 1 = 0x80: neither zero nor positive
    pw(0, ins(LDI, 0, 8'h7F)); pw(1, ins(INC, 0, 0)); pw(2, ins(OUT, 0, 0));
    pw(3, ins(HLT, 0, 0));
    sb.push_back(8'h80);
    go();
    wait_halt("t2_halt_a");
    chk("t2_aeq0_80", 32'(Aeq0), 32'd0);
    chk("t2_apos_80", 32'(Apos), 32'd0);
    pw(0, ins(LDI, 0, 8'h7F)); pw(1, ins(INC, 0, 0)); pw(2, ins(STR, 2, 0));
    pw(3, ins(SUB, 2, 0));     pw(4, ins(HLT, 0, 0));
    go();
    wait_halt("t2_halt_b");
    chk("t2_aeq0_sub", 32'(Aeq0), 32'd1);
    chk("t2_apos_sub", 32'(Apos), 32'd0);

    // Data memory, register file and conditional jumps taken / not taken
    pw(0,  ins(LDI, 0, 8'h11)); pw(1,  ins(STA, 0, 8'd40)); pw(2,  ins(LDI, 0, 8'h00));
    pw(3,  ins(LDA, 0, 8'd40)); pw(4,  ins(OUT, 0, 0));     pw(5,  ins(JZ,  0, 8'd9));
    pw(6,  ins(JP,  0, 8'd8));  pw(7,  ins(HLT, 0, 0));     pw(8,  ins(LDI, 0, 8'hF0));
    pw(9,  ins(STR, 3, 0));     pw(10, ins(LDI, 0, 8'h00)); pw(11, ins(JZ,  0, 8'd13));
    pw(12, ins(HLT, 0, 0));     pw(13, ins(LDR, 3, 0));     pw(14, ins(OUT, 0, 0));
    pw(15, ins(JP,  0, 8'd0));  pw(16, ins(HLT, 0, 0));
    sb.push_back(8'h11);
    sb.push_back(8'hF0);
    go();
    wait_halt("t3_halt");
    chk("t3_apos_neg", 32'(Apos), 32'd0);

    // IN held off for 10 cycles; Prog_we and Start must be ignored meanwhile
    pw(0, ins(IN, 0, 0)); pw(1, ins(OUT, 0, 0)); pw(2, ins(HLT, 0, 0));
    sb.push_back(8'h2A);
    go();
    tick(); tick();
    cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      if (In_ready === 1'b1 && Busy === 1'b1) cnt++;
      Prog_we = (i == 3); Prog_addr = AW'(2); Prog_data = ins(OUT, 0, 0);
      Start = (i == 5);
      if (i == 10) begin In_valid = 1'b1; Input = 8'h2A; end
      tick();
    end
    Prog_we = 1'b0; Start = 1'b0; In_valid = 1'b0;
    chk("t4_in_ready_cycles", cnt, 32'd11);
    chk("t4_in_ready_drop", 32'(In_ready), 32'd0);
    wait_halt("t4_halt");

    // OUT stalled by Out_ready low for 5 cycles
    pw(0, ins(LDI, 0, 8'h3C)); pw(1, ins(OUT, 0, 0)); pw(2, ins(HLT, 0, 0));
    Out_ready = 1'b0;
    sb.push_back(8'h3C);
    go();
    repeat (4) tick();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (Out_valid === 1'b1 && Output === 8'h3C) cnt++;
      tick();
    end
    chk("t5_stall_stable", cnt, 32'd5);
    chk("t5_still_valid", 32'(Out_valid), 32'd1);
    Out_ready = 1'b1;
    tick();
    chk("t5_valid_drop", 32'(Out_valid), 32'd0);
    chk("t5_output_held", 32'(Output), 32'h3C);
    wait_halt("t5_halt");

    // JMP 63 with NOP at 63 wraps PC to 0; second pass exits via JZ
    pulse_reset();
    pw(0, ins(INC, 0, 0));     pw(1, ins(OUT, 0, 0));     pw(2, ins(STR, 1, 0));
    pw(3, ins(LDI, 0, 8'hFE)); pw(4, ins(ADD, 1, 0));     pw(5, ins(JZ,  0, 8'd8));
    pw(6, ins(LDR, 1, 0));     pw(7, ins(JMP, 0, 8'd63)); pw(8, ins(HLT, 0, 0));
    pw(63, ins(NOP, 0, 0));
    sb.push_back(8'd1);
    sb.push_back(8'd2);
    go();
    wait_halt("t6_wrap_halt");

    // JR -2 from address 3 lands on address 2
    pw(0, ins(LDI, 0, 8'd7)); pw(1, ins(JMP, 0, 8'd3)); pw(2, ins(JMP, 0, 8'd5));
    pw(3, ins(JR, 0, 8'hFE)); pw(4, ins(HLT, 0, 0));    pw(5, ins(OUT, 0, 0));
    pw(6, ins(HLT, 0, 0));
    sb.push_back(8'd7);
    go();
    wait_halt("t7_jr_halt");

    // Asynchronous reset while waiting in WAIT_OUT
    pw(0, ins(LDI, 0, 8'h99)); pw(1, ins(OUT, 0, 0)); pw(2, ins(HLT, 0, 0));
    Out_ready = 1'b0;
    go();
    cnt = 0;
    while (Out_valid !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    chk("t8_reached_wait_out", 32'(Out_valid), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("t8_async_out_valid", 32'(Out_valid), 32'd0);
    chk("t8_async_output",    32'(Output),    32'd0);
    chk("t8_async_busy",      32'(Busy),      32'd0);
    chk("t8_async_aeq0",      32'(Aeq0),      32'd1);
    tick();
    Reset = 1'b1;
    Out_ready = 1'b1;
    tick();
    pw(0, ins(LDI, 0, 8'h42)); pw(2, ins(OUT, 0, 0)); pw(3, ins(HLT, 0, 0));
    sb.push_back(8'h43);
    Prog_we = 1'b1; Prog_addr = AW'(1); Prog_data = ins(INC, 0, 0);
    Start = 1'b1;
    tick();
    Prog_we = 1'b0; Start = 1'b0;
    wait_halt("t8_rerun_halt");

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
